// File: rtl/cordic_phase_sequencer_if.sv
// Handshake bundle around cordic_phase_sequencer: request in, cordic_sine core side, result out.
// The slave modport is the sequencer's view; master is the surrounding system (sources, core, sink).
interface cordic_phase_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_phase;
  logic             in_is_cos;

  logic             cs_start;
  logic [WIDTH-1:0] cs_angle;
  logic             cs_ready;
  logic             cs_done;
  logic [WIDTH-1:0] cs_value;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic             out_is_cos;
  logic             out_err;

  modport slave (
    input  in_valid, in_phase, in_is_cos,
    input  cs_ready, cs_done, cs_value,
    input  out_ready,
    output in_ready,
    output cs_start, cs_angle,
    output out_valid, out_value, out_is_cos, out_err
  );

  modport master (
    output in_valid, in_phase, in_is_cos,
    output cs_ready, cs_done, cs_value,
    output out_ready,
    input  in_ready,
    input  cs_start, cs_angle,
    input  out_valid, out_value, out_is_cos, out_err
  );

endinterface

// File: rtl/cordic_phase_sequencer.sv
// Folds full-circle sin/cos phase requests into the cordic_sine angle domain [-pi/2, pi/2)
// and runs one core transaction at a time, with a WAIT timeout and a backpressured result.
module cordic_phase_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                     clk,
  input logic                     reset_n,
  cordic_phase_sequencer_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] QUARTER   = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic [WIDTH-1:0] HALF      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ANGLE_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             accept;
  logic             launch;
  logic             in_wait;
  logic             hit_done;
  logic             hit_timeout;
  logic             release_out;

  logic [CNT_W-1:0] wait_cnt;
  logic             req_is_cos;

  logic [WIDTH-1:0] fold_p;
  logic [WIDTH-1:0] fold_r;
  logic [WIDTH-1:0] fold_angle;

  // Quadrants 01/10 are mirrored via sin(pi - theta); exact pi/2 would wrap to -pi/2, so clamp.
  always_comb begin
    fold_p = bus.in_phase + (bus.in_is_cos ? QUARTER : '0);
    fold_r = HALF - fold_p;
    if (fold_p == QUARTER)
      fold_angle = ANGLE_MAX;
    else if (fold_p[WIDTH-1] ^ fold_p[WIDTH-2])
      fold_angle = {fold_r[WIDTH-2:0], 1'b0};
    else
      fold_angle = {fold_p[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)                    state_nxt = S_ISSUE;
      S_ISSUE: if (launch)                    state_nxt = S_WAIT;
      S_WAIT:  if (hit_done || hit_timeout)   state_nxt = S_OUT;
      S_OUT:   if (release_out)               state_nxt = S_IDLE;
      default:                                state_nxt = S_IDLE;
    endcase
  end

  // A done on the last allowed WAIT cycle still wins over the timeout.
  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_OUT);
    in_wait       = (state == S_WAIT);
    accept        = (state == S_IDLE) && bus.in_valid;
    launch        = (state == S_ISSUE) && bus.cs_ready;
    hit_done      = in_wait && bus.cs_done;
    hit_timeout   = in_wait && !bus.cs_done && (wait_cnt == CNT_LAST);
    release_out   = (state == S_OUT) && bus.out_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.cs_start   <= 1'b0;
      bus.cs_angle   <= '0;
      bus.out_value  <= '0;
      bus.out_is_cos <= 1'b0;
      bus.out_err    <= 1'b0;
      req_is_cos     <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      if (accept) begin
        bus.cs_angle <= fold_angle;
        req_is_cos   <= bus.in_is_cos;
      end

      if (state == S_ISSUE)
        wait_cnt <= '0;
      else if (in_wait)
        wait_cnt <= wait_cnt + 1'b1;

      if (launch)
        bus.cs_start <= 1'b1;

      if (hit_done) begin
        bus.cs_start   <= 1'b0;
        bus.out_value  <= bus.cs_value;
        bus.out_err    <= 1'b0;
        bus.out_is_cos <= req_is_cos;
      end else if (hit_timeout) begin
        bus.cs_start   <= 1'b0;
        bus.out_value  <= '0;
        bus.out_err    <= 1'b1;
        bus.out_is_cos <= req_is_cos;
      end
    end
  end

  angle_stable_a: assert property (@(posedge clk) disable iff (!reset_n)
    bus.cs_start |=> (!bus.cs_start || $stable(bus.cs_angle)));

  result_held_a: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_value) && $stable(bus.out_err) && $stable(bus.out_is_cos)));

endmodule
